// File: rtl/cache_arbiter_pkg.sv
// Shared types and widths for the I/D cache arbiter in front of the single pmem port.
// Holds the FSM state and requester-side encodings plus small grant helpers.
package cache_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_LINE_W = 128;

    typedef logic [ARB_LINE_W-1:0] lc3b_c_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

    function automatic arb_side_t other_side(input arb_side_t side);
        return (side == SIDE_I) ? SIDE_D : SIDE_I;
    endfunction

    function automatic arb_state_t serve_state(input arb_side_t side);
        return (side == SIDE_I) ? SERVE_I : SERVE_D;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Whole-line memory transaction port: requester drives read/write/address/wdata,
// responder returns rdata with a single-cycle resp pulse.
interface cache_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/cache_arbiter_chk.sv
// Protocol checks for the arbiter: a requester must not raise read and write
// together, and pmem must not complete while no transaction is outstanding.
module cache_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic i_read,
    input logic i_write,
    input logic d_read,
    input logic d_write,
    input logic idle,
    input logic pmem_resp
);

    i_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(i_read && i_write))
        else $error("I-side raised read and write together");

    d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write))
        else $error("D-side raised read and write together");

    resp_in_idle: assert property (@(posedge clk) disable iff (!rst_n) !(idle && pmem_resp))
        else $error("pmem_resp arrived with no outstanding transaction");

endmodule

// File: rtl/cache_arbiter_mux.sv
// Return-path steering: only the side currently being served sees pmem rdata/resp;
// the other side gets zero data and no completion pulse.
module arbiter_mux
    import cache_arbiter_pkg::*;
#(
    parameter int LINE_W = ARB_LINE_W
) (
    input  arb_state_t        state,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp
);

    // select the granted side's return path
    always_comb begin
        i_rdata = '0;
        i_resp  = 1'b0;
        d_rdata = '0;
        d_resp  = 1'b0;
        case (state)
            SERVE_I: begin
                i_rdata = pmem_rdata;
                i_resp  = pmem_resp;
            end
            SERVE_D: begin
                d_rdata = pmem_rdata;
                d_resp  = pmem_resp;
            end
            default: begin
                i_rdata = '0;
                i_resp  = 1'b0;
                d_rdata = '0;
                d_resp  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-side and D-side caches: grants one
// whole-line transaction at a time, round-robin under contention, and routes the response back.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic           clk,
    input  logic           rst_n,
    cache_arbiter_if.slave  icache,
    cache_arbiter_if.slave  dcache,
    cache_arbiter_if.master pmem
);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    arb_side_t         last_grant_r;
    arb_side_t         winner_s;
    logic              grant_s;
    logic              req_i_s;
    logic              req_d_s;
    logic              busy_s;
    logic              win_write_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [LINE_W-1:0] win_wdata_s;
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LINE_W-1:0] wdata_r;
    logic [LINE_W-1:0] i_rdata_s;
    logic [LINE_W-1:0] d_rdata_s;
    logic              i_resp_s;
    logic              d_resp_s;

    // pick a winner in IDLE and decide the next state
    always_comb begin
        req_i_s     = icache.read | icache.write;
        req_d_s     = dcache.read | dcache.write;
        winner_s    = last_grant_r;
        grant_s     = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_i_s && req_d_s) begin
                    winner_s = other_side(last_grant_r);
                    grant_s  = 1'b1;
                end else if (req_d_s) begin
                    winner_s = SIDE_D;
                    grant_s  = 1'b1;
                end else if (req_i_s) begin
                    winner_s = SIDE_I;
                    grant_s  = 1'b1;
                end else begin
                    grant_s  = 1'b0;
                end
                if (grant_s) begin
                    state_nxt_s = serve_state(winner_s);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem.resp) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // A side asserting read and write together is treated as a write.
    always_comb begin
        if (winner_s == SIDE_D) begin
            win_write_s = dcache.write;
            win_addr_s  = dcache.address;
            win_wdata_s = dcache.wdata;
        end else begin
            win_write_s = icache.write;
            win_addr_s  = icache.address;
            win_wdata_s = icache.wdata;
        end
    end

    // FSM state and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= SIDE_I;
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                last_grant_r <= winner_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // transaction latches captured at grant time so pmem never sees live inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (grant_s) begin
            write_r <= win_write_s;
            addr_r  <= win_addr_s;
            wdata_r <= win_wdata_s;
        end else begin
            write_r <= write_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    assign busy_s       = (state_r != IDLE);
    assign pmem.read    = busy_s & ~write_r;
    assign pmem.write   = busy_s & write_r;
    assign pmem.address = addr_r;
    assign pmem.wdata   = wdata_r;

    arbiter_mux #(
        .LINE_W (LINE_W)
    ) u_mux (
        .state      (state_r),
        .pmem_rdata (pmem.rdata),
        .pmem_resp  (pmem.resp),
        .i_rdata    (i_rdata_s),
        .i_resp     (i_resp_s),
        .d_rdata    (d_rdata_s),
        .d_resp     (d_resp_s)
    );

    assign icache.rdata = i_rdata_s;
    assign icache.resp  = i_resp_s;
    assign dcache.rdata = d_rdata_s;
    assign dcache.resp  = d_resp_s;

    cache_arbiter_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (icache.read),
        .i_write   (icache.write),
        .d_read    (dcache.read),
        .d_write   (dcache.write),
        .idle      (state_r == IDLE),
        .pmem_resp (pmem.resp)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a transaction-level model (one outstanding line op,
// round-robin pointer) is checked every cycle, plus literal expectations per scenario.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    localparam int AW = ARB_ADDR_W;
    localparam int LW = ARB_LINE_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) icache ();
    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) dcache ();
    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) pmem ();

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .icache (icache),
        .dcache (dcache),
        .pmem   (pmem)
    );

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Model: at most one outstanding line op; side 0 = I, 1 = D.
    logic          m_busy, m_side, m_write, m_last;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    wire m_ri  = icache.read | icache.write;
    wire m_rd  = dcache.read | dcache.write;
    wire m_win = (m_ri && m_rd) ? ~m_last : m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_side <= 1'b0; m_write <= 1'b0; m_last <= 1'b0;
            m_addr <= '0;   m_wdata <= '0;
        end else if (m_busy) begin
            if (pmem.resp) m_busy <= 1'b0;
        end else if (m_ri || m_rd) begin
            m_busy  <= 1'b1;
            m_side  <= m_win;
            m_last  <= m_win;
            m_write <= m_win ? dcache.write   : icache.write;
            m_addr  <= m_win ? dcache.address : icache.address;
            m_wdata <= m_win ? dcache.wdata   : icache.wdata;
        end
    end

    int   resp_log[$];
    int   n_read_rises = 0;
    logic prev_pread = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("pmem_read",  pmem.read,  m_busy && !m_write);
            check("pmem_write", pmem.write, m_busy && m_write);
            check("i_resp", icache.resp, m_busy && !m_side && pmem.resp);
            check("d_resp", dcache.resp, m_busy &&  m_side && pmem.resp);
            check("i_rdata", icache.rdata, (m_busy && !m_side) ? pmem.rdata : '0);
            check("d_rdata", dcache.rdata, (m_busy &&  m_side) ? pmem.rdata : '0);
            if (m_busy) begin
                check("pmem_address", pmem.address, m_addr);
                check("pmem_wdata",   pmem.wdata,   m_wdata);
            end
            if (icache.resp) resp_log.push_back(0);
            if (dcache.resp) resp_log.push_back(1);
            if (pmem.read && !prev_pread) n_read_rises <= n_read_rises + 1;
        end
        prev_pread <= pmem.read;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop_i();
        icache.read = 1'b0; icache.write = 1'b0;
    endtask

    task automatic drop_d();
        dcache.read = 1'b0; dcache.write = 1'b0;
    endtask

    // wait for a pmem strobe, answer lat cycles later; optionally drop the served request
    task automatic complete(input int lat, input logic [LW-1:0] data, input bit auto_drop);
        int waited = 0;
        while (!(pmem.read || pmem.write) && waited < 20) begin
            tick(1);
            waited++;
        end
        check("strobe_seen", pmem.read || pmem.write, 1'b1);
        if (pmem.read || pmem.write) begin
            tick(lat);
            pmem.resp = 1'b1; pmem.rdata = data;
            #1;
            if (auto_drop && icache.resp) drop_i();
            if (auto_drop && dcache.resp) drop_d();
            tick(1);
            pmem.resp = 1'b0; pmem.rdata = '0;
        end
    endtask

    task automatic do_reset();
        drop_i(); drop_d();
        pmem.resp = 1'b0; pmem.rdata = '0;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lc3b_c_line  wd;
        logic [31:0] w;
        int          r0;
        drop_i(); drop_d();
        icache.address = '0; icache.wdata = '0;
        dcache.address = '0; dcache.wdata = '0;
        pmem.resp = 1'b0; pmem.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pmem_read",  pmem.read,  1'b0);
        check("rst_pmem_write", pmem.write, 1'b0);
        check("rst_i_resp", icache.resp, 1'b0);
        check("rst_d_resp", dcache.resp, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // 1: I-only read of 0x1230
        icache.read = 1'b1; icache.address = 16'h1230;
        #3 check("t1_cyc0_read", pmem.read, 1'b0);
        tick(1);
        check("t1_cyc1_read", pmem.read, 1'b1);
        check("t1_cyc1_addr", pmem.address, 16'h1230);
        tick(3);
        pmem.resp = 1'b1; pmem.rdata = {4{32'hA1B2_C3D4}};
        #1;
        check("t1_i_resp",  icache.resp, 1'b1);
        check("t1_i_rdata", icache.rdata, {4{32'hA1B2_C3D4}});
        check("t1_d_resp",  dcache.resp, 1'b0);
        drop_i();
        tick(1);
        pmem.resp = 1'b0; pmem.rdata = '0;
        #1;
        check("t1_cyc5_i_resp", icache.resp, 1'b0);
        check("t1_cyc5_read",   pmem.read, 1'b0);

        // 2: simultaneous I read / D write right after reset -> D first
        do_reset();
        resp_log.delete();
        wd = {4{32'h5EED_F00D}};
        icache.read = 1'b1;  icache.address = 16'h0040;
        dcache.write = 1'b1; dcache.address = 16'h8000; dcache.wdata = wd;
        tick(1);
        check("t2_d_write", pmem.write, 1'b1);
        check("t2_d_read",  pmem.read, 1'b0);
        check("t2_d_addr",  pmem.address, 16'h8000);
        check("t2_d_wdata", pmem.wdata, wd);
        complete(2, '0, 1'b1);
        check("t2_idle_read",  pmem.read, 1'b0);
        check("t2_idle_write", pmem.write, 1'b0);
        tick(1);
        check("t2_i_read", pmem.read, 1'b1);
        check("t2_i_addr", pmem.address, 16'h0040);
        complete(2, {4{32'h0BAD_CAFE}}, 1'b1);
        check("t2_n_resp", resp_log.size(), 2);
        check("t2_first",  (resp_log.size() > 0) ? resp_log[0] : 9, 1);
        check("t2_second", (resp_log.size() > 1) ? resp_log[1] : 9, 0);

        // 3: sustained contention, 4 transactions per side -> D,I,D,I,...
        resp_log.delete();
        icache.read = 1'b1; icache.address = 16'h1000;
        dcache.read = 1'b1; dcache.address = 16'h2000;
        for (int k = 0; k < 8; k++) begin
            w = 32'hC0DE_0000 + 32'(k);
            complete(2, {4{w}}, 1'b0);
            if (k % 2 == 0) begin
                dcache.address = 16'h2000 + 16'(16 * (k / 2 + 1));
                dcache.write   = ~dcache.write;
                dcache.read    = ~dcache.write;
                dcache.wdata   = {4{~w}};
                if (k == 6) drop_d();
            end else begin
                icache.address = icache.address + 16'h0010;
                if (k == 7) drop_i();
            end
        end
        check("t3_n_resp", resp_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_order_%0d", k), (resp_log.size() > k) ? resp_log[k] : 9, (k % 2 == 0) ? 1 : 0);
        end
        tick(2);
        check("t3_done_read",  pmem.read, 1'b0);
        check("t3_done_write", pmem.write, 1'b0);

        // 4: d_read held through d_resp cycle, dropped in the next IDLE cycle
        r0 = n_read_rises;
        dcache.read = 1'b1; dcache.address = 16'h0AA0;
        complete(2, {4{32'h1357_9BDF}}, 1'b0);
        drop_d();
        tick(4);
        check("t4_single_read", n_read_rises - r0, 1);
        check("t4_idle_read", pmem.read, 1'b0);

        // 5: async reset while SERVE_D reads
        dcache.read = 1'b1; dcache.address = 16'h3000;
        tick(1);
        check("t5_pre_read", pmem.read, 1'b1);
        #1 rst_n = 1'b0;
        #1 pmem.resp = 1'b1;
        check("t5_rst_read", pmem.read, 1'b0);
        check("t5_rst_d_resp", dcache.resp, 1'b0);
        #1 pmem.resp = 1'b0;
        drop_d();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("t5_post_read", pmem.read, 1'b0);
        icache.read = 1'b1; icache.address = 16'h0400;
        dcache.read = 1'b1; dcache.address = 16'h0500;
        tick(1);
        check("t5_grant_d_addr", pmem.address, 16'h0500);
        complete(1, {4{32'h2468_ACE0}}, 1'b1);
        complete(1, {4{32'h1122_3344}}, 1'b1);

        // 6: I address changes mid-transaction; pmem keeps the latched one
        tick(1);
        icache.read = 1'b1; icache.address = 16'h0100;
        tick(1);
        check("t6_addr_a", pmem.address, 16'h0100);
        icache.address = 16'h0200;
        tick(1);
        check("t6_addr_b", pmem.address, 16'h0100);
        tick(1);
        check("t6_addr_c", pmem.address, 16'h0100);
        complete(1, {4{32'h7777_0100}}, 1'b1);
        tick(2);
        check("t6_idle_read", pmem.read, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
